// File: rtl/cic_comp_pkg.sv
// Shared types, default widths and compensation coefficients for the CIC compensation FIR.
// Coefficients are Q1.15, symmetric, summing to 32768 so DC gain is exactly one.
package cic_comp_pkg;

   localparam int unsigned NTAPS_DEF     = 16;
   localparam int unsigned DIN_W_DEF     = 22;
   localparam int unsigned COEF_W_DEF    = 16;
   localparam int unsigned DOUT_W_DEF    = 16;
   localparam int unsigned OUT_SHIFT_DEF = 21;

   typedef enum logic [1:0] {
      StIdle,
      StMac,
      StRound
   } fir_state_e;

   localparam logic signed [15:0] COEF [16] = '{
      -16'sd40,   16'sd112,   16'sd256,  -16'sd96,
      -16'sd728,  16'sd512,   16'sd2976,  16'sd13392,
      16'sd13392, 16'sd2976,  16'sd512,  -16'sd728,
      -16'sd96,   16'sd256,   16'sd112,  -16'sd40
   };

   // Taps beyond the stored table read as zero.
   function automatic logic signed [15:0] coef_at(input int unsigned k);
      return (k < 16) ? COEF[k[3:0]] : '0;
   endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Signed multiply-accumulate with synchronous clear and enable; one product per clock.
module cic_comp_mac #(
   parameter int unsigned A_W   = 22,
   parameter int unsigned B_W   = 16,
   parameter int unsigned ACC_W = 42
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [A_W-1:0]   a_i,
   input  logic signed [B_W-1:0]   b_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic signed [A_W+B_W-1:0] prod;
   logic signed [ACC_W-1:0]   acc_q;

   assign prod  = a_i * b_i;
   assign acc_o = acc_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         acc_q <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_q + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/cic_comp_fir.sv
// Serial CIC compensation FIR: accepts one sample, runs NTAPS MAC cycles, then rounds,
// saturates and emits one output with a single-cycle valid pulse.
module cic_comp_fir
   import cic_comp_pkg::*;
#(
   parameter int unsigned NTAPS     = NTAPS_DEF,
   parameter int unsigned DIN_W     = DIN_W_DEF,
   parameter int unsigned COEF_W    = COEF_W_DEF,
   parameter int unsigned DOUT_W    = DOUT_W_DEF,
   parameter int unsigned OUT_SHIFT = OUT_SHIFT_DEF
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     valid_i,
   input  logic signed [DIN_W-1:0]  data_i,
   output logic                     ready_o,
   output logic signed [DOUT_W-1:0] data_o,
   output logic                     valid_o
);

   localparam int unsigned CNT_W = $clog2(NTAPS);
   localparam int unsigned ACC_W = DIN_W + COEF_W + CNT_W;

   localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (OUT_SHIFT - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DOUT_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   fir_state_e               state_q, state_d;
   logic [CNT_W-1:0]         tap_q;
   logic signed [DIN_W-1:0]  x_q [NTAPS];
   logic signed [DIN_W-1:0]  x_sel;
   logic signed [COEF_W-1:0] coef_sel;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  rnd;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [DOUT_W-1:0] sat;
   logic signed [DOUT_W-1:0] data_q;
   logic                     valid_q;
   logic                     accept;
   logic                     mac_clr;
   logic                     mac_en;

   assign ready_o  = (state_q == StIdle);
   assign data_o   = data_q;
   assign valid_o  = valid_q;
   assign x_sel    = x_q[tap_q];
   assign coef_sel = COEF_W'(coef_at(32'(tap_q)));

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (valid_i) begin
               accept  = 1'b1;
               mac_clr = 1'b1;
               state_d = StMac;
            end
         end
         StMac: begin
            mac_en = 1'b1;
            if (tap_q == CNT_W'(NTAPS - 1)) begin
               state_d = StRound;
            end
         end
         StRound: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         tap_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= (state_q == StMac) ? tap_q + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i] <= '0;
         end
      end else if (accept) begin
         x_q[0] <= data_i;
         for (int i = 1; i < NTAPS; i++) begin
            x_q[i] <= x_q[i-1];
         end
      end
   end

   cic_comp_mac #(
      .A_W   (DIN_W),
      .B_W   (COEF_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  (mac_clr),
      .en_i   (mac_en),
      .a_i    (x_sel),
      .b_i    (coef_sel),
      .acc_o  (acc)
   );

   // Round half up, then clamp to the output range.
   always_comb begin
      rnd     = acc + HALF;
      shifted = rnd >>> OUT_SHIFT;
      if (shifted > SAT_MAX) begin
         sat = SAT_MAX[DOUT_W-1:0];
      end else if (shifted < SAT_MIN) begin
         sat = SAT_MIN[DOUT_W-1:0];
      end else begin
         sat = shifted[DOUT_W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= (state_q == StRound);
         if (state_q == StRound) begin
            data_q <= sat;
         end
      end
   end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: a reference model pushes expected outputs per accepted
// sample into a queue, which is popped and compared whenever valid_o is seen.
module tb_cic_comp_fir;

   localparam int NT = 16;

   logic               clk_i = 1'b0;
   logic               rstn_i;
   logic               valid_i;
   logic signed [21:0] data_i;
   logic               ready_o;
   logic signed [15:0] data_o;
   logic               valid_o;

   always #5 clk_i = ~clk_i;

   cic_comp_fir dut (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .valid_o (valid_o)
   );

   longint coef_m [NT] = '{-40, 112, 256, -96, -728, 512, 2976, 13392,
                           13392, 2976, 512, -728, -96, 256, 112, -40};
   longint hist [NT];
   longint exp_q [$];
   longint acc_t_q [$];

   int     n_checks = 0;
   int     n_pass   = 0;
   int     n_fail   = 0;
   longint cyc      = 0;
   bit     acc_flag;
   bit     b2b      = 1'b0;
   bit     have_last;
   longint last_acc;
   int     rdy_low;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   function automatic longint model_out();
      longint acc = 0;
      longint r;
      for (int k = 0; k < NT; k++) acc += hist[k] * coef_m[k];
      r = (acc + (longint'(1) << 20)) >>> 21;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   // Called at the falling edge: checks outputs and models an acceptance at the next edge.
   task automatic observe();
      acc_flag = 1'b0;
      if (valid_o) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", valid_o, 0);
         end else begin
            chk("data_o", data_o, exp_q.pop_front());
            chk("latency", cyc - acc_t_q.pop_front(), 17);
         end
      end
      if (!ready_o) rdy_low++;
      if (valid_i && ready_o && rstn_i) begin
         for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = data_i;
         exp_q.push_back(model_out());
         acc_t_q.push_back(cyc + 1);
         if (b2b && have_last) begin
            chk("acc_spacing", cyc + 1 - last_acc, 18);
            chk("ready_low", rdy_low, 17);
         end
         have_last = 1'b1;
         last_acc  = cyc + 1;
         rdy_low   = 0;
         acc_flag  = 1'b1;
      end
   endtask

   task automatic cycle();
      @(negedge clk_i);
      observe();
      @(posedge clk_i);
      cyc++;
      #1;
   endtask

   task automatic send(input longint d);
      int n = 0;
      valid_i = 1'b1;
      data_i  = d[21:0];
      acc_flag = 1'b0;
      while (!acc_flag && n < 40) begin
         cycle();
         n++;
      end
      if (!acc_flag) chk("accept_timeout", acc_flag, 1);
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 400) begin
         cycle();
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
      for (int i = 0; i < 3; i++) cycle();
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      #1;
      chk("rst_valid_o", valid_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_ready_o", ready_o, 1);
      exp_q.delete();
      acc_t_q.delete();
      for (int k = 0; k < NT; k++) hist[k] = 0;
      have_last = 1'b0;
      cycle();
      cycle();
      rstn_i = 1'b1;
   endtask

   initial begin
      rstn_i  = 1'b1;
      valid_i = 1'b0;
      data_i  = '0;
      #1;
      do_reset();

      // Impulse: near-full-scale sample then zeros reproduces the coefficients.
      send(2097151);
      for (int i = 1; i < NT; i++) send(0);
      drain();

      // Positive DC saturates, negative DC reaches the most negative code without wrapping.
      for (int i = 0; i < 20; i++) send(2097151);
      drain();
      chk("pos_dc_sat", data_o, 32767);
      for (int i = 0; i < 20; i++) send(-2097152);
      drain();
      chk("neg_dc_sat", data_o, -32768);

      // Abort in the middle of the MAC phase.
      send(2097151);
      for (int i = 0; i < 8; i++) cycle();
      do_reset();
      for (int i = 0; i < 30; i++) cycle();
      send(2097151);
      for (int i = 1; i < NT; i++) send(0);
      drain();

      // valid_i held high for 100 clocks.
      b2b       = 1'b1;
      have_last = 1'b0;
      valid_i   = 1'b1;
      data_i    = 22'($urandom);
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (acc_flag) data_i = 22'($urandom);
      end
      valid_i = 1'b0;
      b2b     = 1'b0;
      drain();

      // A lone product of -2^20 rounds to 0; +2^20 rounds to 1.
      do_reset();
      send(-4096);
      send(0);
      send(0);
      drain();
      chk("round_neg_half", data_o, 0);
      do_reset();
      send(4096);
      send(0);
      send(0);
      drain();
      chk("round_pos_half", data_o, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
